sd_read_supervisor: RTL



---
 rtl/sd_read_supervisor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sd_read_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : sd_read_supervisor
// Purpose  : Resets, starts and watches the SD file reader; retries on stall.
// Revision : 1.0 - initial release
// ============================================================================
module sd_read_supervisor #(
  parameter int unsigned TIMEOUT_CYCLES = 200000000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RESET_HOLD     = 16,
  parameter int unsigned DONE_STATE     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  fatstate,
  input  logic        file_found,
  input  logic        outreq,
  output logic        reader_rst_n,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [3:0]  retry_cnt,
  output logic [31:0] byte_cnt
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [IDLE_W-1:0] C_IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);
  localparam logic [3:0]        C_RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [2:0]        C_DONE_ENC    = 3'(DONE_STATE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_WAIT     = 3'd2,
    S_DONE     = 3'd3,
    S_FAIL     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               rst_n_q, rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic [1:0]         code_q, code_d;
  logic [3:0]         retry_q, retry_d;
  logic [31:0]        bytes_q, bytes_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [2:0]         fat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rst_n_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 2'd0;
      retry_q <= 4'd0;
      bytes_q <= 32'd0;
      hold_q  <= '0;
      idle_q  <= '0;
      fat_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      retry_q <= retry_d;
      bytes_q <= bytes_d;
      hold_q  <= hold_d;
      idle_q  <= idle_d;
      fat_q   <= fatstate;
    end
  end

  always_comb begin
    state_d = state_q;
    rst_n_d = rst_n_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    code_d  = code_q;
    retry_d = retry_q;
    bytes_d = bytes_q;
    hold_d  = hold_q;
    idle_d  = idle_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        // abort beats a coincident start even where abort itself has no effect
        if (start && !abort) begin
          state_d = S_RST_HOLD;
          rst_n_d = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          code_d  = 2'd0;
          retry_d = 4'd0;
          bytes_d = 32'd0;
          hold_d  = '0;
        end
      end

      S_RST_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          rst_n_d = 1'b0;
          busy_d  = 1'b0;
        end else if (hold_q == C_HOLD_LAST) begin
          state_d = S_WAIT;
          rst_n_d = 1'b1;
          idle_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          rst_n_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          if (outreq && (bytes_q != 32'hFFFF_FFFF)) begin
            bytes_d = bytes_q + 32'd1;
          end
          if (fatstate == C_DONE_ENC) begin
            busy_d = 1'b0;
            if (file_found) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_FAIL;
              fail_d  = 1'b1;
              code_d  = 2'd1;
              rst_n_d = 1'b0;
            end
          end else if (outreq || (fatstate != fat_q)) begin
            idle_d = '0;
          end else if (idle_q == C_IDLE_LAST) begin
            if (retry_q == C_RETRY_LIMIT) begin
              state_d = S_FAIL;
              fail_d  = 1'b1;
              code_d  = 2'd2;
              busy_d  = 1'b0;
              rst_n_d = 1'b0;
            end else begin
              state_d = S_RST_HOLD;
              retry_d = retry_q + 4'd1;
              bytes_d = 32'd0;
              hold_d  = '0;
              rst_n_d = 1'b0;
            end
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        rst_n_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign reader_rst_n = rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign fail_code    = code_q;
  assign retry_cnt    = retry_q;
  assign byte_cnt     = bytes_q;

endmodule
`default_nettype wire
